strobe_generator: RTL and testbench

- Produces a burst of strobe pulses on a single output line. It is the transmit-side counterpart of the rising-edge strobe latch.
- Used to stimulate time-tagger input channels on-chip, both for self-test and for calibrating channel delay. Its output feeds a channel's strobe input directly.
- Burst shape is programmed per request: pulse count, high width and low gap. A start/busy/done handshake frames each burst.

---
 rtl/strobe_generator.sv | 121 ++++++++++++
 tb/tb_strobe_generator.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/strobe_generator.sv
// Programmable strobe burst generator: N pulses of H high cycles
// separated by L low cycles, framed by a start/busy/done handshake.
module strobe_generator #(
    parameter int CNT_W = 16,
    parameter int WID_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] pulse_count,
    input  logic [WID_W-1:0] high_cycles,
    input  logic [WID_W-1:0] low_cycles,
    output logic             strobe,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HIGH,
        S_LOW,
        S_DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] pulse_rem;
    logic [WID_W-1:0] phase_cnt;
    logic [WID_W-1:0] high_lat;
    logic [WID_W-1:0] low_lat;

    logic [WID_W-1:0] high_clamp;
    logic [WID_W-1:0] low_clamp;
    logic             phase_end;
    logic             last_pulse;

    // Zero widths behave as one cycle so adjacent pulses never merge.
    assign high_clamp = (high_cycles == '0) ? WID_W'(1) : high_cycles;
    assign low_clamp  = (low_cycles == '0) ? WID_W'(1) : low_cycles;
    assign phase_end  = (phase_cnt == '0);
    assign last_pulse = (pulse_rem == CNT_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            pulse_rem <= '0;
            phase_cnt <= '0;
            high_lat  <= '0;
            low_lat   <= '0;
            strobe    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        pulse_rem <= pulse_count;
                        high_lat  <= high_clamp;
                        low_lat   <= low_clamp;
                        if (pulse_count == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= S_HIGH;
                            strobe    <= 1'b1;
                            busy      <= 1'b1;
                            phase_cnt <= high_clamp - WID_W'(1);
                        end
                    end
                end
                S_HIGH: begin
                    if (abort) begin
                        state  <= S_DONE;
                        strobe <= 1'b0;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end else if (phase_end) begin
                        pulse_rem <= pulse_rem - CNT_W'(1);
                        strobe    <= 1'b0;
                        if (last_pulse) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state     <= S_LOW;
                            phase_cnt <= low_lat - WID_W'(1);
                        end
                    end else begin
                        phase_cnt <= phase_cnt - WID_W'(1);
                    end
                end
                S_LOW: begin
                    if (abort) begin
                        state  <= S_DONE;
                        strobe <= 1'b0;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end else if (phase_end) begin
                        state     <= S_HIGH;
                        strobe    <= 1'b1;
                        phase_cnt <= high_lat - WID_W'(1);
                    end else begin
                        phase_cnt <= phase_cnt - WID_W'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state  <= S_IDLE;
                    strobe <= 1'b0;
                    busy   <= 1'b0;
                    done   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_strobe_generator.sv
// Bench for strobe_generator: directed and random bursts checked
// cycle by cycle against a waveform list built from the burst shape.
module tb_strobe_generator;

    localparam int CNT_W = 16;
    localparam int WID_W = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] pulse_count;
    logic [WID_W-1:0] high_cycles;
    logic [WID_W-1:0] low_cycles;
    logic             strobe;
    logic             busy;
    logic             done;

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic s;
        logic b;
        logic d;
    } exp_t;

    exp_t q[$];

    int run_len = 0;
    int widths[$];

    strobe_generator #(
        .CNT_W(CNT_W),
        .WID_W(WID_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .pulse_count(pulse_count),
        .high_cycles(high_cycles),
        .low_cycles (low_cycles),
        .strobe     (strobe),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge-detect monitor in the style of a tagger input: measures high runs.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            run_len = 0;
        end else if (strobe) begin
            run_len++;
        end else if (run_len > 0) begin
            widths.push_back(run_len);
            run_len = 0;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Expected per-cycle waveform from the cycle after start onward.
    function automatic void build(input int n, input int h, input int l,
                                  input int ab);
        int hc;
        int lc;
        q.delete();
        hc = (h == 0) ? 1 : h;
        lc = (l == 0) ? 1 : l;
        for (int p = 0; p < n; p++) begin
            for (int c = 0; c < hc; c++) q.push_back('{1'b1, 1'b1, 1'b0});
            if (p < n - 1)
                for (int c = 0; c < lc; c++) q.push_back('{1'b0, 1'b1, 1'b0});
        end
        if (ab > 0)
            while (q.size() > ab) void'(q.pop_back());
        q.push_back('{1'b0, 1'b0, 1'b1});
    endfunction

    // Called at posedge+1 of an IDLE cycle; returns at posedge+1 of the
    // first IDLE cycle after done, where the next start may be applied.
    task automatic run_burst(input string tag, input int n, input int h,
                             input int l, input int ab);
        pulse_count = n[CNT_W-1:0];
        high_cycles = h[WID_W-1:0];
        low_cycles  = l[WID_W-1:0];
        start = 1'b1;
        abort = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        pulse_count = CNT_W'($urandom);
        high_cycles = WID_W'($urandom);
        low_cycles  = WID_W'($urandom);
        build(n, h, l, ab);
        for (int i = 0; i < q.size(); i++) begin
            if (ab > 0 && i == ab - 1)
                abort = 1'b1;
            else if (i == q.size() - 1)
                abort = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk({tag, ".strobe"}, int'(strobe), int'(q[i].s));
            chk({tag, ".busy"}, int'(busy), int'(q[i].b));
            chk({tag, ".done"}, int'(done), int'(q[i].d));
            @(posedge clk);
            #1;
            abort = 1'b0;
        end
    endtask

    initial begin
        exp_t rt[3];
        int n;
        int h;
        int l;
        int len;
        int ab;

        rst = 1'b1;
        start = 1'b1;
        abort = 1'b0;
        pulse_count = 16'd3;
        high_cycles = 8'd2;
        low_cycles = 8'd1;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst.strobe", int'(strobe), 0);
            chk("rst.busy", int'(busy), 0);
            chk("rst.done", int'(done), 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle.strobe", int'(strobe), 0);
            chk("idle.busy", int'(busy), 0);
            chk("idle.done", int'(done), 0);
        end
        @(posedge clk);
        #1;

        run_burst("basic", 3, 2, 1, 0);
        run_burst("back2back", 2, 1, 3, 0);
        run_burst("clamp", 2, 0, 0, 0);
        run_burst("zero", 0, 5, 5, 0);

        widths.delete();
        run_burst("abort", 5, 4, 4, 10);
        chk("abort.npulses", widths.size(), 2);
        if (widths.size() == 2) begin
            chk("abort.w0", widths[0], 4);
            chk("abort.w1", widths[1], 2);
        end

        widths.delete();
        run_burst("max", 2, 255, 1, 0);
        chk("max.npulses", widths.size(), 2);
        if (widths.size() == 2) begin
            chk("max.w0", widths[0], 255);
            chk("max.w1", widths[1], 255);
        end

        // start held high: strobe, done, idle repeating every 3 cycles.
        rt[0] = '{1'b1, 1'b1, 1'b0};
        rt[1] = '{1'b0, 1'b0, 1'b1};
        rt[2] = '{1'b0, 1'b0, 1'b0};
        pulse_count = 16'd1;
        high_cycles = 8'd1;
        low_cycles = 8'd1;
        start = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk("retrig.strobe", int'(strobe), int'(rt[i % 3].s));
            chk("retrig.busy", int'(busy), int'(rt[i % 3].b));
            chk("retrig.done", int'(done), int'(rt[i % 3].d));
            if (i == 8) start = 1'b0;
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("retrig.stop", int'(strobe), 0);
        @(posedge clk);
        #1;

        for (int k = 0; k < 12; k++) begin
            n = $urandom_range(0, 5);
            h = $urandom_range(0, 6);
            l = $urandom_range(0, 6);
            len = (n == 0) ? 0 :
                  n * ((h == 0) ? 1 : h) + (n - 1) * ((l == 0) ? 1 : l);
            ab = (len > 0 && $urandom_range(0, 2) == 0) ?
                 $urandom_range(1, len) : 0;
            run_burst("rand", n, h, l, ab);
        end

        // Reset mid-burst drops strobe at once and yields no done pulse.
        pulse_count = 16'd3;
        high_cycles = 8'd3;
        low_cycles = 8'd2;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #2;
        chk("pre_rst.strobe", int'(strobe), 1);
        rst = 1'b1;
        #1;
        chk("async_rst.strobe", int'(strobe), 0);
        chk("async_rst.busy", int'(busy), 0);
        chk("async_rst.done", int'(done), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("post_rst.strobe", int'(strobe), 0);
            chk("post_rst.done", int'(done), 0);
        end
        @(posedge clk);
        #1;
        run_burst("after_rst", 1, 2, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
